// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// hands fetched words to decode over valid/ready and squashes wrong-path fetches.
module inst_fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            in_clk,
    input  logic            in_rst,
    output logic            out_imem_req,
    output logic [XLEN-1:0] out_imem_addr,
    input  logic            in_imem_ack,
    input  logic [31:0]     in_imem_data,
    output logic            out_valid,
    input  logic            in_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            in_redirect,
    input  logic [XLEN-1:0] in_redirect_pc
);

    localparam int unsigned INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pend_pc;
    logic [INST_W-1:0] inst_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   redirect_pc_c;
    logic [XLEN-1:0]   pc_plus4_c;

    // Fetch addresses are always word aligned; low bits of a redirect are dropped.
    assign redirect_pc_c = in_redirect_pc & ~XLEN'(3);
    assign pc_plus4_c    = pc + XLEN'(4);

    assign out_inst = inst_q;
    assign out_pc   = pc_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            pend_pc       <= RESET_PC;
            inst_q        <= NOP_INST;
            pc_q          <= RESET_PC;
            out_imem_req  <= 1'b0;
            out_imem_addr <= RESET_PC;
            out_valid     <= 1'b0;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (!out_imem_req) begin
                        // First cycle out of reset: raise the request, no ack can be pending.
                        out_imem_req <= 1'b1;
                        if (in_redirect) begin
                            pc            <= redirect_pc_c;
                            out_imem_addr <= redirect_pc_c;
                        end else begin
                            out_imem_addr <= pc;
                        end
                    end else if (in_redirect) begin
                        if (in_imem_ack) begin
                            pc            <= redirect_pc_c;
                            out_imem_addr <= redirect_pc_c;
                        end else begin
                            pend_pc <= redirect_pc_c;
                            state   <= S_FLUSH;
                        end
                    end else if (in_imem_ack) begin
                        inst_q       <= in_imem_data;
                        pc_q         <= pc;
                        pc           <= pc_plus4_c;
                        out_imem_req <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (in_redirect) begin
                        pc            <= redirect_pc_c;
                        out_imem_addr <= redirect_pc_c;
                        out_imem_req  <= 1'b1;
                        out_valid     <= 1'b0;
                        state         <= S_REQ;
                    end else if (in_ready) begin
                        out_imem_addr <= pc;
                        out_imem_req  <= 1'b1;
                        out_valid     <= 1'b0;
                        state         <= S_REQ;
                    end
                end

                S_FLUSH: begin
                    // Stale request stays on the bus until memory acks it.
                    if (in_imem_ack) begin
                        pc            <= in_redirect ? redirect_pc_c : pend_pc;
                        out_imem_addr <= in_redirect ? redirect_pc_c : pend_pc;
                        state         <= S_REQ;
                    end else if (in_redirect) begin
                        pend_pc <= redirect_pc_c;
                    end
                end

                default: begin
                    state        <= S_REQ;
                    out_imem_req <= 1'b1;
                    out_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: per-cycle vector table plus
// hand-written throughput and PC-wrap sequences.
module tb_inst_fetch_unit;

    localparam int unsigned XLEN = 64;

    typedef struct {
        logic            rst;
        logic            ack;
        logic [31:0]     data;
        logic            ready;
        logic            redirect;
        logic [XLEN-1:0] rpc;
        logic            e_req;
        logic [XLEN-1:0] e_addr;
        logic            e_valid;
        logic [31:0]     e_inst;
        logic [XLEN-1:0] e_pc;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst, ack, ready, redirect;
    logic [31:0]     data;
    logic [XLEN-1:0] rpc;
    logic            req, valid;
    logic [XLEN-1:0] addr, pc;
    logic [31:0]     inst;

    logic            rst_w, ack_w, ready_w, redirect_w;
    logic [31:0]     data_w;
    logic [XLEN-1:0] rpc_w;
    logic            req_w, valid_w;
    logic [XLEN-1:0] addr_w, pc_w;
    logic [31:0]     inst_w;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    inst_fetch_unit #(.XLEN(XLEN), .RESET_PC(64'h0)) dut (
        .in_clk(clk), .in_rst(rst),
        .out_imem_req(req), .out_imem_addr(addr),
        .in_imem_ack(ack), .in_imem_data(data),
        .out_valid(valid), .in_ready(ready),
        .out_inst(inst), .out_pc(pc),
        .in_redirect(redirect), .in_redirect_pc(rpc)
    );

    inst_fetch_unit #(.XLEN(XLEN), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
        .in_clk(clk), .in_rst(rst_w),
        .out_imem_req(req_w), .out_imem_addr(addr_w),
        .in_imem_ack(ack_w), .in_imem_data(data_w),
        .out_valid(valid_w), .in_ready(ready_w),
        .out_inst(inst_w), .out_pc(pc_w),
        .in_redirect(redirect_w), .in_redirect_pc(rpc_w)
    );

    task automatic chk(input string name, input int step, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic a, input logic [31:0] d, input logic rd,
                       input logic rdr, input logic [XLEN-1:0] rp,
                       input logic eq, input logic [XLEN-1:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [XLEN-1:0] ep);
        vec_t v;
        v.rst = r; v.ack = a; v.data = d; v.ready = rd; v.redirect = rdr; v.rpc = rp;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_pc = ep;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0; data = '0; ready = 1'b0; redirect = 1'b0; rpc = '0;
        rst_w = 1'b1; ack_w = 1'b0; data_w = '0; ready_w = 1'b0; redirect_w = 1'b0; rpc_w = '0;

        //   rst ack data          rdy rdr rpc        | req addr      vld inst          pc
        add(1, 0, 32'h0,          0, 0, 64'h0,      0, 64'h0,     0, 32'h0000_0013, 64'h0);   // reset
        add(0, 0, 32'h0,          0, 0, 64'h0,      1, 64'h0,     0, 32'h0000_0013, 64'h0);   // first request
        add(0, 1, 32'hA000_0000,  1, 0, 64'h0,      0, 64'h0,     1, 32'hA000_0000, 64'h0);
        add(0, 1, 32'h0,          1, 0, 64'h0,      1, 64'h4,     0, 32'hA000_0000, 64'h0);
        add(0, 1, 32'hA000_0001,  1, 0, 64'h0,      0, 64'h4,     1, 32'hA000_0001, 64'h4);
        add(0, 1, 32'h0,          1, 0, 64'h0,      1, 64'h8,     0, 32'hA000_0001, 64'h4);
        add(0, 1, 32'hA000_0002,  0, 0, 64'h0,      0, 64'h8,     1, 32'hA000_0002, 64'h8);   // stall begins
        add(0, 0, 32'h0,          0, 0, 64'h0,      0, 64'h8,     1, 32'hA000_0002, 64'h8);
        add(0, 0, 32'h0,          0, 0, 64'h0,      0, 64'h8,     1, 32'hA000_0002, 64'h8);
        add(0, 0, 32'h0,          0, 0, 64'h0,      0, 64'h8,     1, 32'hA000_0002, 64'h8);
        add(0, 0, 32'h0,          0, 0, 64'h0,      0, 64'h8,     1, 32'hA000_0002, 64'h8);
        add(0, 0, 32'h0,          1, 0, 64'h0,      1, 64'hC,     0, 32'hA000_0002, 64'h8);   // pc_q+4
        add(0, 0, 32'h0,          0, 1, 64'h100,    1, 64'hC,     0, 32'hA000_0002, 64'h8);   // redirect in wait
        add(0, 0, 32'h0,          0, 0, 64'h0,      1, 64'hC,     0, 32'hA000_0002, 64'h8);
        add(0, 1, 32'hDEAD_DEAD,  0, 0, 64'h0,      1, 64'h100,   0, 32'hA000_0002, 64'h8);   // stale ack dropped
        add(0, 1, 32'hB000_0000,  0, 0, 64'h0,      0, 64'h100,   1, 32'hB000_0000, 64'h100);
        add(0, 0, 32'h0,          1, 1, 64'h40,     1, 64'h40,    0, 32'hB000_0000, 64'h100); // redirect with transfer
        add(0, 0, 32'h0,          0, 1, 64'h200,    1, 64'h40,    0, 32'hB000_0000, 64'h100);
        add(0, 0, 32'h0,          0, 1, 64'h300,    1, 64'h40,    0, 32'hB000_0000, 64'h100); // last redirect wins
        add(0, 1, 32'hDEAD_DEAD,  0, 0, 64'h0,      1, 64'h300,   0, 32'hB000_0000, 64'h100);
        add(0, 1, 32'hDEAD_BEEF,  0, 1, 64'h503,    1, 64'h500,   0, 32'hB000_0000, 64'h100); // redirect+ack, misaligned
        add(0, 0, 32'h0,          0, 0, 64'h0,      1, 64'h500,   0, 32'hB000_0000, 64'h100);
        add(0, 0, 32'h0,          0, 1, 64'h600,    1, 64'h500,   0, 32'hB000_0000, 64'h100);
        add(0, 1, 32'hDEAD_DEAD,  0, 1, 64'h707,    1, 64'h704,   0, 32'hB000_0000, 64'h100); // redirect on flush ack
        add(0, 1, 32'hC000_0000,  1, 0, 64'h0,      0, 64'h704,   1, 32'hC000_0000, 64'h704);
        add(0, 0, 32'h0,          1, 0, 64'h0,      1, 64'h708,   0, 32'hC000_0000, 64'h704);
        add(0, 0, 32'h0,          0, 0, 64'h0,      1, 64'h708,   0, 32'hC000_0000, 64'h704);
        add(1, 1, 32'hDEAD_DEAD,  0, 0, 64'h0,      0, 64'h0,     0, 32'h0000_0013, 64'h0);   // reset mid-wait
        add(0, 0, 32'h0,          0, 0, 64'h0,      1, 64'h0,     0, 32'h0000_0013, 64'h0);
        add(0, 1, 32'hE000_0000,  0, 0, 64'h0,      0, 64'h0,     1, 32'hE000_0000, 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; ack = vecs[i].ack; data = vecs[i].data;
            ready = vecs[i].ready; redirect = vecs[i].redirect; rpc = vecs[i].rpc;
            @(posedge clk); #1;
            chk("req",   i, 64'(req),   64'(vecs[i].e_req));
            chk("addr",  i, addr,       vecs[i].e_addr);
            chk("valid", i, 64'(valid), 64'(vecs[i].e_valid));
            chk("inst",  i, 64'(inst),  64'(vecs[i].e_inst));
            chk("pc",    i, pc,         vecs[i].e_pc);
        end

        // Peak throughput from S_HOLD (pc_q=0): request/hold alternate, addresses step by 4.
        ack = 1'b1; ready = 1'b1; redirect = 1'b0;
        for (int c = 0; c < 8; c++) begin
            data = 32'hF000_0000 + 32'(c);
            @(posedge clk); #1;
            if (c % 2 == 0) begin
                chk("tp_valid", c, 64'(valid), 64'd0);
                chk("tp_addr",  c, addr, 64'(4 * (c / 2 + 1)));
            end else begin
                chk("tp_valid", c, 64'(valid), 64'd1);
                chk("tp_pc",    c, pc, 64'(4 * ((c + 1) / 2)));
                chk("tp_inst",  c, 64'(inst), 64'(32'hF000_0000 + 32'(c)));
            end
        end

        // PC wrap from the top of the address space.
        @(posedge clk); #1;
        rst_w = 1'b0;
        @(posedge clk); #1;
        chk("wrap_req0",  0, 64'(req_w), 64'd1);
        chk("wrap_addr0", 0, addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
        ack_w = 1'b1; data_w = 32'h1234_5678;
        @(posedge clk); #1;
        chk("wrap_valid", 1, 64'(valid_w), 64'd1);
        chk("wrap_pc",    1, pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
        ack_w = 1'b0; ready_w = 1'b1;
        @(posedge clk); #1;
        chk("wrap_req1",  2, 64'(req_w), 64'd1);
        chk("wrap_addr1", 2, addr_w, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
